// File: rtl/line_burst_master.sv
// Single-outstanding burst master: cache-line refills become read bursts and
// writebacks become write bursts. Optional BURST_PROTOCOL_CHECK_EN adds a sticky proto_err output.
package line_burst_master_pkg;
    typedef struct packed {
        logic        arvalid;
        logic [31:0] araddr;
        logic [3:0]  rlen;
        logic        rready;
        logic        awvalid;
        logic [31:0] waddr;
        logic [3:0]  wlen;
        logic        wvalid;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wlast;
        logic        bready;
    } bus_query_req_t;

    // rready here acknowledges the read address phase.
    typedef struct packed {
        logic        rready;
        logic        rvalid;
        logic [31:0] rdata;
        logic        rlast;
        logic        awready;
        logic        wready;
        logic        bvalid;
    } bus_query_resp_t;
endpackage

module line_burst_master
    import line_burst_master_pkg::*;
#(
    parameter int LINE_WORDS = 8,
    parameter int IDX_W      = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rd_req_valid,
    input  logic [31:0]             rd_req_addr,
    output logic                    rd_req_ready,
    output logic                    rd_data_valid,
    output logic [31:0]             rd_data,
    output logic [IDX_W-1:0]        rd_data_idx,
    output logic                    rd_data_last,
    input  logic                    wb_req_valid,
    input  logic [31:0]             wb_req_addr,
    input  logic [32*LINE_WORDS-1:0] wb_req_line,
    output logic                    wb_req_ready,
    output logic                    wb_done,
    output logic                    busy,
    output logic [113:0]            bus_req,
    input  logic [37:0]             bus_resp
`ifdef BURST_PROTOCOL_CHECK_EN
    ,
    output logic                    proto_err
`endif
);

    localparam int OFF_BITS = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) + 2 : 2;
    localparam logic [31:0] ALIGN_MASK = ~((32'd1 << OFF_BITS) - 32'd1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_ADDR = 3'd3,
        WR_DATA = 3'd4,
        WR_RESP = 3'd5
    } state_t;

    state_t                          state_q, state_d;
    logic [IDX_W-1:0]                cnt_q, cnt_d;
    logic [31:0]                     addr_q, addr_d;
    logic [LINE_WORDS-1:0][31:0]     buf_q;
    logic                            rd_valid_q, rd_last_q;
    logic [31:0]                     rd_data_q;
    logic [IDX_W-1:0]                rd_idx_q;

    bus_query_req_t  req_c;
    bus_query_resp_t resp;
    logic            buf_load, rd_beat, wb_done_c;

    assign resp = bus_resp;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        req_c        = '0;
        rd_req_ready = 1'b0;
        wb_req_ready = 1'b0;
        wb_done_c    = 1'b0;
        rd_beat      = 1'b0;
        buf_load     = 1'b0;
        case (state_q)
            IDLE: begin
                // Writeback wins so a dirty victim leaves before its refill.
                if (wb_req_valid) begin
                    wb_req_ready = 1'b1;
                    buf_load     = 1'b1;
                    addr_d       = wb_req_addr & ALIGN_MASK;
                    cnt_d        = '0;
                    state_d      = WR_ADDR;
                end else if (rd_req_valid) begin
                    rd_req_ready = 1'b1;
                    addr_d       = rd_req_addr & ALIGN_MASK;
                    cnt_d        = '0;
                    state_d      = RD_ADDR;
                end
            end
            RD_ADDR: begin
                req_c.arvalid = 1'b1;
                req_c.araddr  = addr_q;
                req_c.rlen    = 4'(LINE_WORDS);
                if (resp.rready) state_d = RD_DATA;
            end
            RD_DATA: begin
                req_c.rready = 1'b1;
                if (resp.rvalid) begin
                    rd_beat = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) state_d = IDLE;
                end
            end
            WR_ADDR: begin
                req_c.awvalid = 1'b1;
                req_c.waddr   = addr_q;
                req_c.wlen    = 4'(LINE_WORDS);
                if (resp.awready) state_d = WR_DATA;
            end
            WR_DATA: begin
                req_c.wvalid = 1'b1;
                req_c.wdata  = buf_q[cnt_q];
                req_c.wstrb  = 4'hF;
                req_c.wlast  = (cnt_q == LAST_IDX);
                if (resp.wready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                req_c.bready = 1'b1;
                if (resp.bvalid) begin
                    wb_done_c = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            buf_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_data_q  <= '0;
            rd_idx_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            if (buf_load) buf_q <= wb_req_line;
            rd_valid_q <= rd_beat;
            rd_last_q  <= rd_beat & (cnt_q == LAST_IDX);
            if (rd_beat) begin
                rd_data_q <= resp.rdata;
                rd_idx_q  <= cnt_q;
            end
        end
    end

    assign bus_req       = req_c;
    assign rd_data_valid = rd_valid_q;
    assign rd_data       = rd_data_q;
    assign rd_data_idx   = rd_idx_q;
    assign rd_data_last  = rd_last_q;
    assign wb_done       = wb_done_c;
    assign busy          = (state_q != IDLE);

`ifdef BURST_PROTOCOL_CHECK_EN
    logic proto_err_q;
    logic proto_evt;

    assign proto_evt = (resp.rvalid & (state_q != RD_DATA))
                     | (resp.bvalid & (state_q != WR_RESP))
                     | ((state_q == RD_DATA) & resp.rvalid & (resp.rlast != (cnt_q == LAST_IDX)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         proto_err_q <= 1'b0;
        else if (proto_evt) proto_err_q <= 1'b1;
    end

    assign proto_err = proto_err_q;
`else
    logic unused_rlast;
    assign unused_rlast = resp.rlast;
`endif

endmodule
